// File: rtl/mem_bus_bridge_pkg.sv
// Shared types and constants for the line-to-beat memory bridge.
package mem_bus_bridge_pkg;

  localparam int CACHE_LINE_SIZE = 512;
  localparam int MEM_BUS_WIDTH   = 128;
  localparam int MEM_BEATS       = CACHE_LINE_SIZE / MEM_BUS_WIDTH;
  localparam int BEAT_IDX_W      = $clog2(MEM_BEATS);
  localparam int BEAT_CNT_W      = BEAT_IDX_W + 1;
  localparam int BYTE_OFS_W      = $clog2(MEM_BUS_WIDTH / 8);
  localparam int LINE_ADDR_W     = 64 - BEAT_IDX_W - BYTE_OFS_W;

  typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} bridge_state_t;

  typedef struct packed {
    logic                       mem_req_load;
    logic                       mem_req_store;
    logic [63:0]                mem_addr;
    logic [CACHE_LINE_SIZE-1:0] mem_data_out;
  } mem_bus_req_t;

  typedef struct packed {
    logic                       mem_ready;
    logic [CACHE_LINE_SIZE-1:0] mem_data;
  } mem_bus_resp_t;

  typedef struct packed {
    logic                     we;
    logic [63:0]              addr;
    logic [MEM_BUS_WIDTH-1:0] wdata;
  } mem_beat_cmd_t;

  // Beat byte address; the beat index never carries into the line address.
  function automatic logic [63:0] beat_addr(input logic [LINE_ADDR_W-1:0] line,
                                            input logic [BEAT_IDX_W-1:0]  beat);
    return {line, beat, {BYTE_OFS_W{1'b0}}};
  endfunction

endpackage

// File: rtl/mem_beat_buffer.sv
// One cache line of storage with a beat-indexed write port and read port.
module mem_beat_buffer
  import mem_bus_bridge_pkg::*;
(
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic                       i_load_line,
  input  logic [CACHE_LINE_SIZE-1:0] i_line,
  input  logic                       i_wr_en,
  input  logic [BEAT_IDX_W-1:0]      i_wr_idx,
  input  logic [MEM_BUS_WIDTH-1:0]   i_wr_data,
  input  logic [BEAT_IDX_W-1:0]      i_rd_idx,
  output logic [MEM_BUS_WIDTH-1:0]   o_rd_data,
  output logic [CACHE_LINE_SIZE-1:0] o_line
);

  logic [CACHE_LINE_SIZE-1:0] r_line;

  // Whole-line load for stores, single-beat capture for read responses.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_line <= '0;
    end else if (i_load_line) begin
      r_line <= i_line;
    end else if (i_wr_en) begin
      r_line[i_wr_idx*MEM_BUS_WIDTH +: MEM_BUS_WIDTH] <= i_wr_data;
    end
  end

  assign o_rd_data = r_line[i_rd_idx*MEM_BUS_WIDTH +: MEM_BUS_WIDTH];
  assign o_line    = r_line;

endmodule

// File: rtl/mem_bus_bridge.sv
// Splits cache line requests into beat commands and reassembles read beats.
module mem_bus_bridge
  import mem_bus_bridge_pkg::*;
(
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  mem_bus_req_t             i_req,
  output mem_bus_resp_t            o_resp,
  output logic                     o_cmd_valid,
  input  logic                     i_cmd_ready,
  output logic                     o_cmd_we,
  output logic [63:0]              o_cmd_addr,
  output logic [MEM_BUS_WIDTH-1:0] o_cmd_wdata,
  input  logic                     i_rsp_valid,
  input  logic [MEM_BUS_WIDTH-1:0] i_rsp_data
);

  localparam logic [BEAT_CNT_W-1:0] LAST_BEAT = BEAT_CNT_W'(MEM_BEATS - 1);

  bridge_state_t              r_state;
  logic [LINE_ADDR_W-1:0]     r_addr;
  logic [BEAT_CNT_W-1:0]      r_issued;
  logic [BEAT_CNT_W-1:0]      r_rcvd;
  logic                       r_cmd_valid;
  mem_beat_cmd_t              r_cmd;
  logic                       r_mem_ready;
  logic [CACHE_LINE_SIZE-1:0] r_mem_data;

  logic [BEAT_CNT_W-1:0]      w_nxt_issued;
  logic [BEAT_IDX_W-1:0]      w_nxt_idx;
  logic [MEM_BUS_WIDTH-1:0]   w_buf_rd;
  logic [CACHE_LINE_SIZE-1:0] w_buf_line;
  logic [CACHE_LINE_SIZE-1:0] w_assembled;
  logic                       w_rsp_take;
  logic                       w_load_line;
  logic                       w_unused_addr;

  assign w_nxt_issued  = r_issued + 1'b1;
  assign w_nxt_idx     = w_nxt_issued[BEAT_IDX_W-1:0];
  assign w_rsp_take    = i_rsp_valid && (r_state == READ) && (r_issued > r_rcvd);
  assign w_load_line   = (r_state == IDLE) && i_req.mem_req_store;
  assign w_unused_addr = ^i_req.mem_addr[63:LINE_ADDR_W];

  mem_beat_buffer u_buf (
    .i_clock     (i_clock),
    .i_reset     (i_reset),
    .i_load_line (w_load_line),
    .i_line      (i_req.mem_data_out),
    .i_wr_en     (w_rsp_take),
    .i_wr_idx    (r_rcvd[BEAT_IDX_W-1:0]),
    .i_wr_data   (i_rsp_data),
    .i_rd_idx    (w_nxt_idx),
    .o_rd_data   (w_buf_rd),
    .o_line      (w_buf_line)
  );

  // Line as it will look once the incoming response beat is captured.
  always_comb begin
    w_assembled = w_buf_line;
    w_assembled[r_rcvd[BEAT_IDX_W-1:0]*MEM_BUS_WIDTH +: MEM_BUS_WIDTH] = i_rsp_data;
  end

  // Bridge FSM with registered command and response outputs.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_issued    <= '0;
      r_rcvd      <= '0;
      r_cmd_valid <= 1'b0;
      r_cmd       <= '0;
      r_mem_ready <= 1'b0;
      r_mem_data  <= '0;
    end else begin
      r_mem_ready <= 1'b0;
      case (r_state)
        IDLE: begin
          r_issued <= '0;
          r_rcvd   <= '0;
          if (i_req.mem_req_store) begin
            r_addr      <= i_req.mem_addr[LINE_ADDR_W-1:0];
            r_cmd       <= '{we: 1'b1,
                             addr: beat_addr(i_req.mem_addr[LINE_ADDR_W-1:0], '0),
                             wdata: i_req.mem_data_out[MEM_BUS_WIDTH-1:0]};
            r_cmd_valid <= 1'b1;
            r_state     <= WRITE;
          end else if (i_req.mem_req_load) begin
            r_addr      <= i_req.mem_addr[LINE_ADDR_W-1:0];
            r_cmd       <= '{we: 1'b0,
                             addr: beat_addr(i_req.mem_addr[LINE_ADDR_W-1:0], '0),
                             wdata: '0};
            r_cmd_valid <= 1'b1;
            r_state     <= READ;
          end
        end
        WRITE, READ: begin
          if (r_cmd_valid && i_cmd_ready) begin
            r_issued <= w_nxt_issued;
            if (r_issued == LAST_BEAT) begin
              r_cmd_valid <= 1'b0;
              if (r_state == WRITE) begin
                r_state     <= RESP;
                r_mem_ready <= 1'b1;
              end
            end else begin
              r_cmd.addr <= beat_addr(r_addr, w_nxt_idx);
              if (r_cmd.we) r_cmd.wdata <= w_buf_rd;
            end
          end
          if (w_rsp_take) begin
            r_rcvd <= r_rcvd + 1'b1;
            if (r_rcvd == LAST_BEAT) begin
              r_state     <= RESP;
              r_mem_ready <= 1'b1;
              r_mem_data  <= w_assembled;
            end
          end
        end
        RESP: begin
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_resp.mem_ready = r_mem_ready;
  assign o_resp.mem_data  = r_mem_data;
  assign o_cmd_valid      = r_cmd_valid;
  assign o_cmd_we         = r_cmd.we;
  assign o_cmd_addr       = r_cmd.addr;
  assign o_cmd_wdata      = r_cmd.wdata;

  // Simultaneous load and store is illegal; the store path is taken.
  a_req_exclusive: assert property (@(posedge i_clock) disable iff (!i_reset)
      !(r_state == IDLE && i_req.mem_req_load && i_req.mem_req_store))
    else $warning("mem_bus_bridge: load and store requested together, store taken");

  // A response without an outstanding read is dropped.
  a_rsp_expected: assert property (@(posedge i_clock) disable iff (!i_reset)
      !i_rsp_valid || w_rsp_take)
    else $warning("mem_bus_bridge: rsp_valid with no outstanding read dropped");

endmodule

// File: tb/tb_mem_bus_bridge.sv
// Randomized bench for mem_bus_bridge with a transaction-level reference model.
module tb_mem_bus_bridge;
  import mem_bus_bridge_pkg::*;

  localparam int K_LOAD  = 0;
  localparam int K_STORE = 1;
  localparam int K_BOTH  = 2;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  mem_bus_req_t  req;
  mem_bus_resp_t resp;
  logic          cmd_valid, cmd_we;
  logic          cmd_ready = 1'b0;
  logic [63:0]   cmd_addr;
  logic [127:0]  cmd_wdata;
  logic          rsp_valid = 1'b0;
  logic [127:0]  rsp_data  = '0;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // environment knobs
  int           rdy_mode  = 0;
  int           mem_lat   = 2;
  int           stray_cyc = -1;
  logic [511:0] mem_pattern = '0;

  // reference model state
  mem_beat_cmd_t exp_q[$];
  mem_beat_cmd_t act_log[$];
  int            rsp_due_q[$];
  logic [127:0]  rsp_data_q[$];
  int            m_txn = 0;       // 0 none, 1 write, 2 read
  int            m_acc = 0;
  int            m_rcv = 0;
  logic [511:0]  m_line = '0;
  logic [511:0]  m_data = '0;
  logic          exp_rdy = 1'b0;
  logic          prev_stall = 1'b0;
  mem_beat_cmd_t prev_cmd;

  mem_bus_bridge dut (
    .i_clock     (clk),
    .i_reset     (rst_n),
    .i_req       (req),
    .o_resp      (resp),
    .o_cmd_valid (cmd_valid),
    .i_cmd_ready (cmd_ready),
    .o_cmd_we    (cmd_we),
    .o_cmd_addr  (cmd_addr),
    .o_cmd_wdata (cmd_wdata),
    .i_rsp_valid (rsp_valid),
    .i_rsp_data  (rsp_data)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory side: drives cmd_ready and in-order read responses just after each edge.
  initial forever begin
    @(posedge clk);
    cyc++;
    #1;
    case (rdy_mode)
      0:       cmd_ready = 1'b1;
      1:       cmd_ready = cyc[0];
      default: cmd_ready = 1'($urandom_range(0, 1));
    endcase
    if (rsp_due_q.size() > 0 && rsp_due_q[0] <= cyc) begin
      rsp_valid = 1'b1;
      rsp_data  = rsp_data_q.pop_front();
      void'(rsp_due_q.pop_front());
    end else if (cyc == stray_cyc) begin
      rsp_valid = 1'b1;
      rsp_data  = 128'hDEAD;
    end else begin
      rsp_valid = 1'b0;
      rsp_data  = '0;
    end
  end

  // Compare process: checks outputs every cycle and advances the model.
  initial forever begin
    logic          rdy_nxt;
    mem_beat_cmd_t e;
    int            due;
    @(negedge clk);
    if (!rst_n) begin
      prev_stall = 1'b0;
      continue;
    end
    check("mem_ready", 512'(resp.mem_ready), 512'(exp_rdy));
    check("mem_data", resp.mem_data, m_data);
    if (prev_stall) begin
      check("stall_valid", 512'(cmd_valid), 512'(1'b1));
      check("stall_addr", 512'(cmd_addr), 512'(prev_cmd.addr));
      check("stall_wdata", 512'(cmd_wdata), 512'(prev_cmd.wdata));
    end
    rdy_nxt = 1'b0;
    if (rsp_valid && m_txn == 2 && m_rcv < m_acc) begin
      m_line[m_rcv*128 +: 128] = rsp_data;
      m_rcv++;
      if (m_rcv == MEM_BEATS) begin
        rdy_nxt = 1'b1;
        m_data  = m_line;
        m_txn   = 0;
      end
    end
    if (cmd_valid && cmd_ready) begin
      act_log.push_back('{we: cmd_we, addr: cmd_addr, wdata: cmd_wdata});
      if (exp_q.size() == 0) begin
        check("spurious_cmd", 512'(cmd_addr), 512'(0));
        if (cmd_addr == 64'd0) begin
          n_fail++;
          $display("FAIL spurious_cmd: got a command at address 0, required none");
        end
      end else begin
        e = exp_q.pop_front();
        check("cmd_we", 512'(cmd_we), 512'(e.we));
        check("cmd_addr", 512'(cmd_addr), 512'(e.addr));
        if (e.we) check("cmd_wdata", 512'(cmd_wdata), 512'(e.wdata));
      end
      m_acc++;
      if (m_txn == 1 && m_acc == MEM_BEATS) begin
        rdy_nxt = 1'b1;
        m_txn   = 0;
      end
      if (!cmd_we) begin
        due = cyc + mem_lat;
        if (rsp_due_q.size() > 0 && due <= rsp_due_q[$]) due = rsp_due_q[$] + 1;
        rsp_due_q.push_back(due);
        rsp_data_q.push_back(mem_pattern[cmd_addr[5:4]*128 +: 128]);
      end
    end
    prev_stall = cmd_valid && !cmd_ready;
    prev_cmd   = '{we: cmd_we, addr: cmd_addr, wdata: cmd_wdata};
    exp_rdy    = rdy_nxt;
  end

  // Cache side: present a registered request and queue the beats it must produce.
  task automatic start_txn(input int kind, input logic [63:0] addr, input logic [511:0] line);
    for (int b = 0; b < MEM_BEATS; b++) begin
      mem_beat_cmd_t e;
      logic [1:0]    bi;
      bi      = 2'(b);
      e.we    = (kind != K_LOAD);
      e.addr  = {addr[57:0], bi, 4'b0000};
      e.wdata = e.we ? line[b*128 +: 128] : '0;
      exp_q.push_back(e);
    end
    m_txn  = (kind != K_LOAD) ? 1 : 2;
    m_acc  = 0;
    m_rcv  = 0;
    m_line = '0;
    req.mem_req_store = (kind != K_LOAD);
    req.mem_req_load  = (kind != K_STORE);
    req.mem_addr      = addr;
    req.mem_data_out  = line;
  endtask

  task automatic wait_done(output int lat);
    bit seen = 0;
    lat = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (resp.mem_ready) seen = 1;
    end
    if (!seen) begin
      n_chk++;
      n_fail++;
      $display("FAIL txn_timeout: got no mem_ready in 300 cycles, required one");
    end
    @(posedge clk);
    #1;
    req.mem_req_store = 1'b0;
    req.mem_req_load  = 1'b0;
  endtask

  task automatic do_txn(input int kind, input logic [63:0] addr, input logic [511:0] line,
                        output int lat);
    start_txn(kind, addr, line);
    wait_done(lat);
  endtask

  function automatic logic [511:0] rand_line();
    logic [511:0] l;
    for (int w = 0; w < 16; w++) l[w*32 +: 32] = $urandom;
    return l;
  endfunction

  initial begin
    int           lat;
    logic [511:0] line;
    logic [511:0] d0;
    req = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_ready", 512'(resp.mem_ready), 512'(0));
    check("rst_mem_data", resp.mem_data, 512'(0));
    check("rst_cmd_valid", 512'(cmd_valid), 512'(0));
    check("rst_cmd_we", 512'(cmd_we), 512'(0));
    check("rst_cmd_addr", 512'(cmd_addr), 512'(0));
    check("rst_cmd_wdata", 512'(cmd_wdata), 512'(0));
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Directed read: byte k of the line holds value k, memory latency 2.
    rdy_mode = 0;
    mem_lat  = 2;
    for (int k = 0; k < 64; k++) mem_pattern[k*8 +: 8] = 8'(k);
    act_log.delete();
    do_txn(K_LOAD, 64'h40, '0, lat);
    check("rd_latency", 512'(lat), 512'(7));
    check("rd_cmd_count", 512'(act_log.size()), 512'(4));
    if (act_log.size() == 4) begin
      check("rd_addr0", 512'(act_log[0].addr), 512'(64'h1000));
      check("rd_addr1", 512'(act_log[1].addr), 512'(64'h1010));
      check("rd_addr2", 512'(act_log[2].addr), 512'(64'h1020));
      check("rd_addr3", 512'(act_log[3].addr), 512'(64'h1030));
    end
    check("rd_beat0", 512'(resp.mem_data[127:0]), 512'(128'h0f0e0d0c0b0a09080706050403020100));
    check("rd_beat3", 512'(resp.mem_data[511:384]), 512'(128'h3f3e3d3c3b3a39383736353433323130));

    // Directed write with cmd_ready toggling.
    rdy_mode = 1;
    line = rand_line();
    act_log.delete();
    do_txn(K_STORE, 64'h2, line, lat);
    check("wr_cmd_count", 512'(act_log.size()), 512'(4));
    if (act_log.size() == 4) begin
      check("wr_addr0", 512'(act_log[0].addr), 512'(64'h80));
      check("wr_addr1", 512'(act_log[1].addr), 512'(64'h90));
      check("wr_addr2", 512'(act_log[2].addr), 512'(64'hA0));
      check("wr_addr3", 512'(act_log[3].addr), 512'(64'hB0));
      check("wr_data3", 512'(act_log[3].wdata), 512'(line[511:384]));
    end

    // Writeback followed immediately by a refill.
    rdy_mode = 0;
    mem_pattern = rand_line();
    act_log.delete();
    do_txn(K_STORE, 64'h123, rand_line(), lat);
    check("wr_latency", 512'(lat), 512'(5));
    do_txn(K_LOAD, 64'h456, '0, lat);
    check("wb_rf_cmd_count", 512'(act_log.size()), 512'(8));
    if (act_log.size() == 8)
      for (int b = 0; b < 8; b++) check("wb_rf_order", 512'(act_log[b].we), 512'(b < 4));
    check("rf_line", resp.mem_data, mem_pattern);

    // Load and store together: the write path must be taken.
    act_log.delete();
    do_txn(K_BOTH, 64'h77, rand_line(), lat);
    check("both_cmd_count", 512'(act_log.size()), 512'(4));
    if (act_log.size() == 4) check("both_we", 512'(act_log[0].we), 512'(1));

    // Reset in the middle of a read, after two beats have been captured.
    mem_lat = 3;
    mem_pattern = rand_line();
    start_txn(K_LOAD, 64'h999, '0);
    for (int i = 0; i < 60 && m_rcv < 2; i++) begin
      @(posedge clk);
      #1;
    end
    check("mid_rcv", 512'(m_rcv), 512'(2));
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_mem_ready", 512'(resp.mem_ready), 512'(0));
    check("arst_mem_data", resp.mem_data, 512'(0));
    check("arst_cmd_valid", 512'(cmd_valid), 512'(0));
    check("arst_cmd_addr", 512'(cmd_addr), 512'(0));
    check("arst_cmd_wdata", 512'(cmd_wdata), 512'(0));
    exp_q.delete();
    rsp_due_q.delete();
    rsp_data_q.delete();
    m_txn   = 0;
    m_data  = '0;
    exp_rdy = 1'b0;
    req     = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    mem_pattern = rand_line();
    do_txn(K_LOAD, 64'h999, '0, lat);
    check("post_rst_line", resp.mem_data, mem_pattern);

    // Stray response while idle.
    repeat (2) @(posedge clk);
    #1;
    d0 = resp.mem_data;
    stray_cyc = cyc + 1;
    repeat (4) @(posedge clk);
    #1;
    check("stray_data", resp.mem_data, d0);
    check("stray_ready", 512'(resp.mem_ready), 512'(0));

    // Randomized traffic.
    for (int t = 0; t < 40; t++) begin
      rdy_mode    = $urandom_range(0, 2);
      mem_lat     = $urandom_range(1, 4);
      mem_pattern = rand_line();
      do_txn($urandom_range(0, 1), {$urandom, $urandom}, rand_line(), lat);
      if ($urandom_range(0, 3) == 0) begin
        stray_cyc = cyc + 1;
        repeat (3) @(posedge clk);
        #1;
      end
    end
    repeat (3) @(posedge clk);
    #1;
    check("final_queue_empty", 512'(exp_q.size()), 512'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_bus_bridge.md
Name: mem_bus_bridge

Overview:
- Sits directly downstream of the L1 data cache.
- Consumes the cache's line-granular mem_bus_req_t and returns mem_bus_resp_t.
- Converts each line request into CACHE_LINE_SIZE/MEM_BUS_WIDTH beats on a narrow command/response memory port.
- Reassembles read beats into a full line and pulses mem_ready once per completed transaction.

Parameters:
- CACHE_LINE_SIZE, 512, line width in bits; must match the cache.
- MEM_BUS_WIDTH, 128, beat width in bits; must divide CACHE_LINE_SIZE.
- BEATS, CACHE_LINE_SIZE/MEM_BUS_WIDTH (4), beats per line; derived, not overridable.

Ports:
- clock  input  1  sole clock; all state on rising edge.
- reset  input  1  one clock; reset is asynchronous and active-low (0 = reset asserted).
- req  input  mem_bus_req_t  line request from cache: mem_req_load, mem_req_store, mem_addr (line address, byte address >> 6), mem_data_out.
- resp  output  mem_bus_resp_t  mem_ready (1-cycle pulse), mem_data (assembled line).
- cmd_valid  output  1  beat command valid.
- cmd_ready  input  1  memory accepts the command on valid&ready.
- cmd_we  output  1  1 = write beat, 0 = read beat.
- cmd_addr  output  64  beat byte address = {mem_addr[57:0], beat[1:0], 4'b0}.
- cmd_wdata  output  MEM_BUS_WIDTH  write beat = line[beat*128 +: 128].
- rsp_valid  input  1  read beat returned, in order, one per issued read.
- rsp_data  input  MEM_BUS_WIDTH  read beat data.

Behaviour:
- Reset values: mem_ready=0, mem_data=0, cmd_valid=0, cmd_we=0, cmd_addr=0, cmd_wdata=0, state=IDLE, counters=0. Reset mid-transaction aborts it. The downstream memory shares this reset, so in-flight beats are discarded.
- States: IDLE, WRITE, READ, RESP.
- IDLE:
  - Samples req each edge.
  - mem_req_store=1 → latch mem_addr and mem_data_out, go to WRITE. Store has priority if load and store are both set; that combination is illegal and flagged by an assertion.
  - Else mem_req_load=1 → latch mem_addr, go to READ.
- WRITE:
  - cmd_valid=1, cmd_we=1, beat counter issues beats 0..BEATS-1.
  - Counter advances only on cmd_valid&cmd_ready.
  - cmd_addr and cmd_wdata are held stable while cmd_ready=0.
  - After beat BEATS-1 is accepted: cmd_valid=0, go to RESP.
- READ:
  - Issue counter sends read commands 0..BEATS-1 with the same valid/ready rule. cmd_valid drops once all BEATS are accepted.
  - Receive counter writes rsp_data into line buffer slot [rcv*128 +: 128] on each rsp_valid.
  - Responses may overlap issuing.
  - rsp_valid with no outstanding read is ignored; assertion fires.
  - When the BEATS-th response is captured, go to RESP.
- RESP:
  - Exactly one cycle with mem_ready=1.
  - For reads, mem_data = assembled line, valid this cycle.
  - For writes, mem_data holds its previous value.
  - Then unconditionally go to IDLE without sampling req; the cache's registered req is still high in this cycle.
- mem_data holds its value until the next read completes.
- Minimum latency with cmd_ready=1:
  - Write: req seen cycle 0, beats issued cycles 1..4, mem_ready in cycle 5.
  - Read: mem_ready in the cycle after the last rsp_valid.
- Back-to-back transactions: a writeback followed by a refill is two independent transactions separated by at least one IDLE cycle.
- Address arithmetic: mem_addr bits above 57 are dropped; the beat index occupies address bits [5:4] and does not carry into the line address.

Decomposition:
- Package structures gains:
  - bridge_state_t enum {IDLE, WRITE, READ, RESP}.
  - MEM_BEATS constant.
  - mem_beat_cmd_t struct {we, addr, wdata}.
- One natural sub-module: mem_beat_buffer.
  - CACHE_LINE_SIZE register with beat-indexed write port (rsp capture) and beat-indexed read port (cmd_wdata).
  - Reused by the bridge for both directions.

Test Plan:
- Read, cmd_ready=1, memory returns beats 0x00..0F, 0x10..1F, 0x20..2F, 0x30..3F at latency 2, mem_addr=0x40 → cmd_addr 0x1000, 0x1010, 0x1020, 0x1030; one mem_ready pulse; mem_data[127:0] holds beat 0, [511:384] holds beat 3.
- Write, mem_addr=0x2, mem_data_out=line pattern, cmd_ready toggles 1,0,1,0 → four accepted beats at 0x80, 0x90, 0xA0, 0xB0; cmd_wdata stable while stalled; mem_ready exactly one cycle after the 4th acceptance.
- Writeback then refill, driven by a cache-model bench: store, mem_ready, store drops; load, mem_ready → no spurious second write; write beats precede all read commands.
- Load and store both high → WRITE path taken, assertion reported.
- Reset driven to 0 after 2 of 4 read beats → all outputs 0 immediately (asynchronous). After release, a fresh read completes with only the new beats in mem_data.
- Stray rsp_valid in IDLE with rsp_data=0xDEAD → mem_data unchanged, no mem_ready, assertion reported.
